// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shifts/rotates in both directions, parallel load
// and synchronous clear. Shift operations are counted modulo WIDTH, with a one-cycle pulse on wrap.
module univ_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [2:0]                 mode,
   input  logic [WIDTH-1:0]           load_data,
   input  logic                       serial_in_l,
   input  logic                       serial_in_r,
   output logic [WIDTH-1:0]           data_out,
   output logic                       serial_out_l,
   output logic                       serial_out_r,
   output logic [$clog2(WIDTH)-1:0]   shift_cnt,
   output logic                       word_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ASR  = 3'b101;
   localparam logic [2:0] M_LOAD = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift_op;

   always_comb begin
      data_d   = data_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shift_op = 1'b0;
      if (en) begin
         case (mode)
            M_SHL: begin
               data_d   = {data_q[WIDTH-2:0], serial_in_l};
               shift_op = 1'b1;
            end
            M_SHR: begin
               data_d   = {serial_in_r, data_q[WIDTH-1:1]};
               shift_op = 1'b1;
            end
            M_ROL: begin
               data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               shift_op = 1'b1;
            end
            M_ROR: begin
               data_d   = {data_q[0], data_q[WIDTH-1:1]};
               shift_op = 1'b1;
            end
            M_ASR: begin
               data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
               shift_op = 1'b1;
            end
            M_LOAD: begin
               data_d = load_data;
               cnt_d  = '0;
            end
            M_CLR: begin
               data_d = '0;
               cnt_d  = '0;
            end
            default: ;
         endcase
         // Explicit wrap so non-power-of-two widths still roll over at WIDTH-1.
         if (shift_op) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            done_d = (cnt_q == CNT_LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign data_out     = data_q;
   assign shift_cnt    = cnt_q;
   assign word_done    = done_q;
   assign serial_out_l = data_q[WIDTH-1];
   assign serial_out_r = data_q[0];

   // M_HOLD is the case default; named here for readability of the encoding.
   logic unused_hold;
   assign unused_hold = ^M_HOLD;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): a vector table of per-cycle
// operations with hand-computed results, plus an asynchronous-reset sequence.
module tb_univ_shift_reg;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] load_data;
   logic         serial_in_l;
   logic         serial_in_r;
   logic [W-1:0] data_out;
   logic         serial_out_l;
   logic         serial_out_r;
   logic [2:0]   shift_cnt;
   logic         word_done;

   int n_tests = 0;
   int n_fail  = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .load_data    (load_data),
      .serial_in_l  (serial_in_l),
      .serial_in_r  (serial_in_r),
      .data_out     (data_out),
      .serial_out_l (serial_out_l),
      .serial_out_r (serial_out_r),
      .shift_cnt    (shift_cnt),
      .word_done    (word_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         en;
      logic [2:0]   mode;
      logic [W-1:0] ld;
      logic         sil;
      logic         sir;
      logic [W-1:0] exp_d;
      logic [2:0]   exp_c;
      logic         exp_w;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic e, logic [2:0] m, logic [W-1:0] ld, logic sil, logic sir,
                              logic [W-1:0] ed, logic [2:0] ec, logic ew);
      vec_t r;
      r.en = e; r.mode = m; r.ld = ld; r.sil = sil; r.sir = sir;
      r.exp_d = ed; r.exp_c = ec; r.exp_w = ew;
      return r;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(string tag, logic [W-1:0] ed, logic [2:0] ec, logic ew);
      check({tag, " data_out"}, 64'(data_out), 64'(ed));
      check({tag, " shift_cnt"}, 64'(shift_cnt), 64'(ec));
      check({tag, " word_done"}, 64'(word_done), 64'(ew));
      check({tag, " serial_out_l"}, 64'(serial_out_l), 64'(ed[W-1]));
      check({tag, " serial_out_r"}, 64'(serial_out_r), 64'(ed[0]));
   endtask

   task automatic drive(logic e, logic [2:0] m, logic [W-1:0] ld, logic sil, logic sir);
      en = e; mode = m; load_data = ld; serial_in_l = sil; serial_in_r = sir;
   endtask

   // Apply one operation, let it clock in, and sample 1 time unit after the edge.
   task automatic step(logic e, logic [2:0] m, logic [W-1:0] ld, logic sil, logic sir);
      drive(e, m, ld, sil, sir);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dones;
      // ---- serial shift-in from reset: 1,0,1,1,0,0,1,0 -> 0xB2
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'h01, 3'd1, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h02, 3'd2, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'h05, 3'd3, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'h0B, 3'd4, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h16, 3'd5, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h2C, 3'd6, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'h59, 3'd7, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hB2, 3'd0, 1));
      vecs.push_back(v(1, 3'b000, 8'h00, 0, 0, 8'hB2, 3'd0, 0));
      // ---- load 0xA5, rotate left x8
      vecs.push_back(v(1, 3'b110, 8'hA5, 0, 0, 8'hA5, 3'd0, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h4B, 3'd1, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h96, 3'd2, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h2D, 3'd3, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h5A, 3'd4, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'hB4, 3'd5, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h69, 3'd6, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'hD2, 3'd7, 0));
      vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'hA5, 3'd0, 1));
      vecs.push_back(v(1, 3'b000, 8'h00, 0, 0, 8'hA5, 3'd0, 0));
      // ---- arithmetic vs logical shift right
      vecs.push_back(v(1, 3'b110, 8'h80, 0, 0, 8'h80, 3'd0, 0));
      vecs.push_back(v(1, 3'b101, 8'h00, 0, 0, 8'hC0, 3'd1, 0));
      vecs.push_back(v(1, 3'b101, 8'h00, 0, 0, 8'hE0, 3'd2, 0));
      vecs.push_back(v(1, 3'b101, 8'h00, 0, 0, 8'hF0, 3'd3, 0));
      vecs.push_back(v(1, 3'b110, 8'h80, 0, 0, 8'h80, 3'd0, 0));
      vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'h40, 3'd1, 0));
      vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'h20, 3'd2, 0));
      vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'h10, 3'd3, 0));
      // ---- mixed directions keep counting and wrap
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h08, 3'd4, 0));
      vecs.push_back(v(1, 3'b010, 8'h00, 0, 1, 8'h84, 3'd5, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h08, 3'd6, 0));
      vecs.push_back(v(1, 3'b101, 8'h00, 0, 0, 8'h04, 3'd7, 0));
      vecs.push_back(v(1, 3'b101, 8'h00, 0, 0, 8'h02, 3'd0, 1));
      // ---- enable gating
      vecs.push_back(v(1, 3'b110, 8'h3C, 0, 0, 8'h3C, 3'd0, 0));
      vecs.push_back(v(0, 3'b001, 8'h00, 1, 0, 8'h3C, 3'd0, 0));
      vecs.push_back(v(0, 3'b001, 8'h00, 1, 0, 8'h3C, 3'd0, 0));
      vecs.push_back(v(0, 3'b001, 8'h00, 1, 0, 8'h3C, 3'd0, 0));
      vecs.push_back(v(0, 3'b001, 8'h00, 1, 0, 8'h3C, 3'd0, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'h79, 3'd1, 0));
      vecs.push_back(v(0, 3'b111, 8'h00, 0, 0, 8'h79, 3'd1, 0));
      vecs.push_back(v(0, 3'b110, 8'h00, 0, 0, 8'h79, 3'd1, 0));
      // ---- shifts then load reset the count
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'hBC, 3'd2, 0));
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h5E, 3'd3, 0));
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h2F, 3'd4, 0));
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h97, 3'd5, 0));
      vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'hCB, 3'd6, 0));
      vecs.push_back(v(1, 3'b110, 8'hFF, 0, 0, 8'hFF, 3'd0, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hFE, 3'd1, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hFC, 3'd2, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hF8, 3'd3, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hF0, 3'd4, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hE0, 3'd5, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'hC0, 3'd6, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h80, 3'd7, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h00, 3'd0, 1));
      // ---- clear after a nonzero count
      vecs.push_back(v(1, 3'b110, 8'h5A, 0, 0, 8'h5A, 3'd0, 0));
      vecs.push_back(v(1, 3'b001, 8'h00, 1, 0, 8'hB5, 3'd1, 0));
      vecs.push_back(v(1, 3'b111, 8'h00, 0, 0, 8'h00, 3'd0, 0));

      // ---- clock/reset
      drive(0, 3'b000, 8'h00, 0, 0);
      rst = 1'b1;
      #1;
      check_all("reset", 8'h00, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- table
      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].mode, vecs[i].ld, vecs[i].sil, vecs[i].sir);
         check_all($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_w);
      end

      // ---- asynchronous reset mid-count
      for (int i = 0; i < 5; i++) step(1, 3'b001, 8'h00, 1, 0);
      check_all("pre_rst", 8'h1F, 3'd5, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 8'h00, 3'd0, 1'b0);
      #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 3'b011, 8'h00, 0, 0);
         if (i == 0) check("post_rst first cnt", 64'(shift_cnt), 64'd1);
         if (word_done) dones++;
         if (i == 7) check("post_rst wrap done", 64'(word_done), 64'd1);
      end
      check("post_rst done count", 64'(dones), 64'd1);
      check("post_rst cnt", 64'(shift_cnt), 64'd0);
      step(1, 3'b000, 8'h00, 0, 0);
      check_all("post_rst hold", 8'h00, 3'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete, expected finish before 20000");
      $fatal(1);
   end

endmodule
